// File: rtl/life_pkg.sv
// Shared types and helpers for the multi-channel toroidal Game of Life frame engine.
package life_pkg;
    typedef enum logic [1:0] {WAIT, COMPUTE, COMMIT, STREAM} state_t;

    localparam int SIDE_DEF = 8;
    localparam int CELLS    = SIDE_DEF * SIDE_DEF;
    localparam int IDX_W    = $clog2(CELLS);

    function automatic int cell_idx(input int row, input int col, input int side);
        return row * side + col;
    endfunction
endpackage

// File: rtl/life_frame_engine_rule.sv
// Combinational B3/S23 next-state for one cell of a toroidal board.
module life_cell_rule
    import life_pkg::*;
#(
    parameter int SIDE = 8
) (
    input  logic [SIDE*SIDE-1:0]     board,
    input  logic [$clog2(SIDE)-1:0]  row,
    input  logic [$clog2(SIDE)-1:0]  col,
    output logic                     next
);
    localparam int SW = $clog2(SIDE);
    localparam int IW = $clog2(SIDE * SIDE);

    logic [3:0]    count;
    logic [SW-1:0] r;
    logic [SW-1:0] c;
    logic [IW-1:0] nidx;
    logic          self_alive;

    // Adding SIDE-1 is -1 modulo SIDE; the SW-bit truncation provides the wrap.
    always_comb begin
        count = '0;
        r     = '0;
        c     = '0;
        nidx  = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (!(dr == 1 && dc == 1)) begin
                    r     = row + SW'(dr + SIDE - 1);
                    c     = col + SW'(dc + SIDE - 1);
                    nidx  = IW'(cell_idx(int'(r), int'(c), SIDE));
                    count = count + 4'(board[nidx]);
                end
            end
        end
    end

    assign self_alive = board[IW'(cell_idx(int'(row), int'(col), SIDE))];
    assign next       = (count == 4'd3) | ((count == 4'd2) & self_alive);
endmodule

// File: rtl/life_frame_engine.sv
// Multi-channel Game of Life engine: periodic generation step, run-time board load,
// and row-major pixel streaming over a valid/ready handshake.
module life_frame_engine
    import life_pkg::*;
#(
    parameter int          SIDE      = 8,
    parameter int          CHANNELS  = 3,
    parameter int          GEN_TICKS = 12000000,
    parameter logic [7:0]  BRIGHT    = 8'h20
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            run,
    input  logic                                            load_valid,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_chan,
    input  logic [SIDE*SIDE-1:0]                            load_board,
    output logic                                            load_ready,
    output logic                                            pix_valid,
    input  logic                                            pix_ready,
    output logic [8*CHANNELS-1:0]                           pix_data,
    output logic                                            frame_done,
    output logic [15:0]                                     generation
);
    localparam int NCELL = SIDE * SIDE;
    localparam int IW    = $clog2(NCELL);
    localparam int SW    = $clog2(SIDE);
    localparam int TW    = $clog2(GEN_TICKS);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q;
    logic          pending_q;
    logic          dirty_q;
    logic [IW-1:0] idx_q;
    logic [15:0]   gen_q;
    logic          frame_done_q;

    logic tick_wrap, load_fire, chan_ok, last_idx, go_compute, go_stream;

    assign tick_wrap  = (tick_q == TW'(GEN_TICKS - 1));
    assign load_fire  = load_valid & load_ready;
    assign chan_ok    = int'(load_chan) < CHANNELS;
    assign last_idx   = (idx_q == IW'(NCELL - 1));
    assign go_compute = (state_q == WAIT) & pending_q & run;
    assign go_stream  = (state_q == WAIT) & ~go_compute & dirty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT: begin
                if (pending_q & run) state_d = COMPUTE;
                else if (dirty_q)    state_d = STREAM;
            end
            COMPUTE: if (last_idx) state_d = COMMIT;
            COMMIT:  state_d = STREAM;
            STREAM:  if (pix_ready & last_idx) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        load_ready = (state_q == WAIT) & ~rst;
        pix_valid  = (state_q == STREAM);
    end

    // Sticky requests: a new set in the same cycle as a clear wins, so nothing is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q       <= '0;
            pending_q    <= 1'b0;
            dirty_q      <= 1'b0;
            idx_q        <= '0;
            gen_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_wrap ? '0 : tick_q + TW'(1);
            pending_q    <= (pending_q & ~go_compute) | (tick_wrap & run);
            dirty_q      <= (dirty_q & ~go_stream) | (load_fire & chan_ok);
            frame_done_q <= pix_valid & pix_ready & last_idx;
            if (state_q == COMMIT) begin
                gen_q <= gen_q + 16'd1;
            end
            if ((state_q == COMPUTE) || (pix_valid && pix_ready)) begin
                idx_q <= last_idx ? '0 : idx_q + IW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [NCELL-1:0] board_q;
        logic [NCELL-1:0] shadow_q;
        logic             cell_next;

        life_cell_rule #(.SIDE(SIDE)) u_rule (
            .board (board_q),
            .row   (idx_q[IW-1:SW]),
            .col   (idx_q[SW-1:0]),
            .next  (cell_next)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                board_q  <= '0;
                shadow_q <= '0;
            end else begin
                if (state_q == COMPUTE) begin
                    shadow_q[idx_q] <= cell_next;
                end
                if (state_q == COMMIT) begin
                    board_q <= shadow_q;
                end else if (load_fire && (load_chan == CW'(gi))) begin
                    board_q <= load_board;
                end
            end
        end

        assign pix_data[8*gi +: 8] = (pix_valid && board_q[idx_q]) ? BRIGHT : 8'h00;
    end

    assign frame_done = frame_done_q;
    assign generation = gen_q;
endmodule

// File: tb/tb_life_frame_engine.sv
// Directed bench for life_frame_engine: loads, generations, back-pressure, contention, overrun, reset.
module tb_life_frame_engine;
    import life_pkg::*;

    localparam int          GT = 256;
    localparam logic [7:0]  BR = 8'h20;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0060_6000_0000_0000;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;
    localparam logic [63:0] ZERO    = 64'h0;

    logic        clk = 1'b0;
    logic        rst, run, load_valid, load_ready, pix_valid, pix_ready, frame_done;
    logic [1:0]  load_chan;
    logic [63:0] load_board;
    logic [23:0] pix_data;
    logic [15:0] generation;

    int tests = 0;
    int fails = 0;
    int nrp = 0;
    int at, n, seen;
    logic [23:0] frame [CELLS];

    life_frame_engine #(.SIDE(8), .CHANNELS(3), .GEN_TICKS(GT), .BRIGHT(BR)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .load_valid (load_valid),
        .load_chan  (load_chan),
        .load_board (load_board),
        .load_ready (load_ready),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .generation (generation)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; equals the engine's tick count modulo GT.
    always @(posedge clk) begin
        if (rst) nrp <= 0;
        else     nrp <= nrp + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input logic [63:0] b0, input logic [63:0] b1,
                                            input logic [63:0] b2, input int p);
        logic [5:0] i;
        i = IDX_W'(p);
        return {b2[i] ? BR : 8'h00, b1[i] ? BR : 8'h00, b0[i] ? BR : 8'h00};
    endfunction

    task automatic check_frame(input string tag, input logic [63:0] b0,
                               input logic [63:0] b1, input logic [63:0] b2);
        int bad = 0;
        for (int p = 0; p < CELLS; p++) begin
            if (frame[IDX_W'(p)] !== exp_pix(b0, b1, b2, p)) bad++;
        end
        chk(tag, 64'(bad), 64'(0));
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [63:0] b);
        @(negedge clk);
        load_valid = 1'b1;
        load_chan  = ch;
        load_board = b;
        chk("load_ready", 64'(load_ready), 64'(1));
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int when);
        int k = 0;
        while (!pix_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        when = nrp;
        chk("wait_valid", 64'(pix_valid), 64'(1));
    endtask

    // Accepts one full frame into frame[]; bp=1 randomises pix_ready.
    task automatic collect(input bit bp);
        int p = 0;
        int k = 0;
        int stall_bad = 0;
        int fd_seen = 0;
        bit stalled = 1'b0;
        logic [23:0] held = '0;
        while (p < CELLS && k < 4000) begin
            if (pix_valid) begin
                if (stalled && pix_data !== held) stall_bad++;
                pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pix_ready) begin
                    frame[IDX_W'(p)] = pix_data;
                    p++;
                    stalled = 1'b0;
                end else begin
                    held = pix_data;
                    stalled = 1'b1;
                end
            end else begin
                if (stalled) stall_bad++;
                pix_ready = 1'b0;
            end
            if (frame_done) fd_seen++;
            @(negedge clk);
            k++;
        end
        pix_ready = 1'b0;
        chk("pix_count", 64'(p), 64'(CELLS));
        chk("stall_stable", 64'(stall_bad), 64'(0));
        chk("fd_early", 64'(fd_seen), 64'(0));
        chk("fd_pulse", 64'(frame_done), 64'(1));
        chk("valid_after_last", 64'(pix_valid), 64'(0));
        @(negedge clk);
        load_valid = 1'b0;
        chk("fd_one_cycle", 64'(frame_done), 64'(0));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; load_valid = 1'b0; load_chan = '0;
        load_board = '0; pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load_ready", 64'(load_ready), 64'(0));
        chk("rst_pix_valid", 64'(pix_valid), 64'(0));
        chk("rst_generation", 64'(generation), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_pix_data", 64'(pix_data), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_load_ready", 64'(load_ready), 64'(1));

        do_load(2'd0, BLINK_H);
        collect(1'b0);
        check_frame("frame_load_ch0", BLINK_H, ZERO, ZERO);
        do_load(2'd2, BLOCK);
        collect(1'b0);
        check_frame("frame_load_ch2", BLINK_H, ZERO, BLOCK);
        chk("gen_after_loads", 64'(generation), 64'(0));

        do_load(2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (pix_valid) seen++;
        end
        chk("discard_no_stream", 64'(seen), 64'(0));

        run = 1'b1;
        wait_valid(600, at);
        run = 1'b0;
        chk("gen_latency", 64'(at % GT), 64'(66));
        chk("gen1", 64'(generation), 64'(1));
        collect(1'b0);
        check_frame("frame_gen1", BLINK_V, ZERO, BLOCK);

        run = 1'b1;
        wait_valid(600, at);
        run = 1'b0;
        collect(1'b1);
        check_frame("frame_gen2_bp", BLINK_H, ZERO, BLOCK);
        chk("gen2", 64'(generation), 64'(2));

        run = 1'b1;
        n = 0;
        while (load_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        chk("contention_ready_low", 64'(load_ready), 64'(0));
        load_valid = 1'b1; load_chan = 2'd1; load_board = GLIDER;
        repeat (70) @(negedge clk);
        chk("contention_still_low", 64'(load_ready), 64'(0));
        chk("contention_streaming", 64'(pix_valid), 64'(1));
        collect(1'b0);
        check_frame("frame_gen3", BLINK_V, ZERO, BLOCK);
        chk("gen3", 64'(generation), 64'(3));
        collect(1'b0);
        check_frame("frame_dirty_load", BLINK_V, GLIDER, BLOCK);
        chk("gen3_after_load", 64'(generation), 64'(3));

        for (int g = 0; g < 32; g++) begin
            run = 1'b1;
            wait_valid(600, at);
            if (g == 31) run = 1'b0;
            collect(1'b0);
        end
        check_frame("frame_glider32", BLINK_V, GLIDER, BLOCK);
        chk("gen35", 64'(generation), 64'(35));

        run = 1'b1;
        wait_valid(600, at);
        repeat (1000) @(negedge clk);
        n = 0;
        while ((nrp % GT) != 10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("overrun_stalled_gen", 64'(generation), 64'(36));
        collect(1'b0);
        wait_valid(200, at);
        run = 1'b0;
        chk("overrun_one_extra", 64'(generation), 64'(37));
        collect(1'b0);
        seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (pix_valid) seen++;
        end
        chk("overrun_no_more", 64'(seen), 64'(0));
        chk("gen37_final", 64'(generation), 64'(37));

        run = 1'b1;
        wait_valid(600, at);
        run = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(pix_valid), 64'(0));
        chk("midrst_gen", 64'(generation), 64'(0));
        chk("midrst_fd", 64'(frame_done), 64'(0));
        chk("midrst_data", 64'(pix_data), 64'(0));
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done || pix_valid) seen++;
        end
        chk("midrst_quiet", 64'(seen), 64'(0));
        run = 1'b1;
        wait_valid(600, at);
        run = 1'b0;
        chk("midrst_latency", 64'(at % GT), 64'(66));
        chk("midrst_gen1", 64'(generation), 64'(1));
        collect(1'b0);
        check_frame("frame_after_rst", ZERO, ZERO, ZERO);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
